// File: rtl/secded_enc_pipe.sv
// Two-stage pipelined SECDED (extended Hamming) encoder with valid/ready on both sides.
// Optional error injection at the S1->S2 transfer is enabled by defining SECDED_ERR_INJ_EN.
module secded_enc_pipe #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned PAR_W = $clog2(DATA_W + $clog2(DATA_W) + 1),
  localparam int unsigned CW_W  = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   code_out,
  output logic [CNT_W-1:0]  word_cnt
`ifdef SECDED_ERR_INJ_EN
  ,
  input  logic              inj_en,
  input  logic [CW_W-1:0]   inj_mask
`endif
);

  // Data-bearing Hamming positions covered by parity bit k.
  function automatic logic [CW_W-1:0] cover_mask(input int unsigned k);
    logic [CW_W-1:0] m;
    m = '0;
    for (int unsigned p = 1; p < CW_W; p++) begin
      if ((((p >> k) & 1) != 0) && ((p & (p - 1)) != 0)) begin
        m = m | ((CW_W)'(1) << p);
      end
    end
    return m;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [CW_W-1:0]   s2_code_q,  s2_code_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic              s1_ld_c;
  logic              s2_ld_c;
  logic [CW_W-1:1]   cw_data_c;
  logic [CW_W-1:1]   cw_body_c;
  logic [CW_W-1:0]   code_c;
  logic [CW_W-1:0]   inj_c;

  // Data bits scattered into non-power-of-two positions; parity bits fill the rest.
  for (genvar p = 1; p < CW_W; p++) begin : g_pos
    if ((p & (p - 1)) == 0) begin : g_par
      localparam logic [CW_W-1:0] COVER_FULL = cover_mask($clog2(p));
      assign cw_data_c[p] = 1'b0;
      assign cw_body_c[p] = ^(cw_data_c & COVER_FULL[CW_W-1:1]);
    end else begin : g_dat
      assign cw_data_c[p] = s1_data_q[p - $clog2(p + 1) - 1];
      assign cw_body_c[p] = cw_data_c[p];
    end
  end

  assign code_c = {cw_body_c, ^cw_body_c};

`ifdef SECDED_ERR_INJ_EN
  assign inj_c = inj_en ? inj_mask : '0;
`else
  assign inj_c = '0;
`endif

  // Backpressure chain: a stage may load if it is empty or its successor is moving.
  assign s2_ld_c  = !s2_valid_q || out_ready;
  assign s1_ld_c  = !s1_valid_q || s2_ld_c;
  assign in_ready = s1_ld_c;

  assign out_valid = s2_valid_q;
  assign code_out  = s2_code_q;
  assign word_cnt  = word_cnt_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_code_d  = s2_code_q;
    word_cnt_d = word_cnt_q;

    if (s2_ld_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_code_d = code_c ^ inj_c;
      end
    end

    if (s1_ld_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = data_in;
      end
    end

    // Saturating count of output handoffs.
    if (s2_valid_q && out_ready && (word_cnt_q != '1)) begin
      word_cnt_d = word_cnt_q + (CNT_W)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_code_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_code_q  <= s2_code_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule
